core_image_loader: RTL and testbench

CORE_IMAGE_LOADER -- requirements
Module: core_image_loader

---
 rtl/core_image_loader.sv | 173 +++++++++++++++++
 tb/tb_core_image_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : core_image_loader
// Brief    : Streams a block of 36-bit words into core storage, then
//            optionally holds the operator-panel START button.
// Revision : 1.0
// ============================================================================
module core_image_loader #(
    parameter int START_CYCLES = 1000,
    parameter bit AUTO_START   = 1'b1
) (
    input  logic        CL,
    input  logic        RESET,
    input  logic        LOAD_REQ,
    input  logic [14:0] LOAD_ORG,
    input  logic [14:0] LOAD_COUNT,
    input  logic        ABORT,
    input  logic        WORD_VALID,
    input  logic [35:0] WORD_DATA,
    output logic        WORD_READY,
    input  logic        MEM_BUSY,
    output logic        MEM_WE,
    output logic [14:0] MEM_ADDR,
    output logic [35:0] MEM_DATA,
    output logic        START_PRESS,
    output logic        BUSY,
    output logic        DONE
);

    localparam int C_CNT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_START_LAST = C_CNT_W'(START_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_START  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    state_t             w_end_state;
    logic               req_s_q, req_s_d;
    logic               req_prev_q, req_prev_d;
    logic [14:0]        org_s_q, org_s_d;
    logic [14:0]        cnt_s_q, cnt_s_d;
    logic [14:0]        addr_q, addr_d;
    logic [14:0]        rem_q, rem_d;
    logic [14:0]        mem_addr_q, mem_addr_d;
    logic [35:0]        data_q, data_d;
    logic [C_CNT_W-1:0] start_cnt_q, start_cnt_d;
    logic               word_ready_q, word_ready_d;
    logic               mem_we_q, mem_we_d;
    logic               start_press_q, start_press_d;
    logic               done_q, done_d;

    always_comb begin
        state_d     = state_q;
        // LOAD_REQ and its operands are registered together, so the edge is
        // only seen once a clock edge after reset release has captured them.
        req_s_d     = LOAD_REQ;
        req_prev_d  = req_s_q;
        org_s_d     = LOAD_ORG;
        cnt_s_d     = LOAD_COUNT;
        addr_d      = addr_q;
        rem_d       = rem_q;
        mem_addr_d  = mem_addr_q;
        data_d      = data_q;
        start_cnt_d = start_cnt_q;
        mem_we_d    = 1'b0;

        if (AUTO_START) begin
            w_end_state = ST_START;
        end else begin
            w_end_state = ST_FINISH;
        end

        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s_q && !req_prev_q) begin
                        addr_d  = org_s_q;
                        rem_d   = cnt_s_q;
                        state_d = (cnt_s_q != 15'd0) ? ST_LOAD : w_end_state;
                    end
                end
                ST_LOAD: begin
                    if (WORD_VALID && word_ready_q) begin
                        data_d  = WORD_DATA;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!MEM_BUSY) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = addr_q;
                        addr_d     = addr_q + 15'd1;
                        rem_d      = rem_q - 15'd1;
                        state_d    = (rem_q != 15'd1) ? ST_LOAD : w_end_state;
                    end
                end
                ST_START: begin
                    if (start_cnt_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        start_cnt_d = start_cnt_q - 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if ((state_d == ST_START) && (state_q != ST_START)) begin
            start_cnt_d = C_START_LAST;
        end

        // Strobes are decoded from the next state so they leave a flop clean.
        word_ready_d  = (state_d == ST_LOAD);
        start_press_d = (state_d == ST_START);
        done_d        = (state_d == ST_FINISH);
    end

    always_ff @(posedge CL or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            req_s_q       <= 1'b0;
            req_prev_q    <= 1'b0;
            org_s_q       <= 15'd0;
            cnt_s_q       <= 15'd0;
            addr_q        <= 15'd0;
            rem_q         <= 15'd0;
            mem_addr_q    <= 15'd0;
            data_q        <= 36'd0;
            start_cnt_q   <= '0;
            word_ready_q  <= 1'b0;
            mem_we_q      <= 1'b0;
            start_press_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_s_q       <= req_s_d;
            req_prev_q    <= req_prev_d;
            org_s_q       <= org_s_d;
            cnt_s_q       <= cnt_s_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            mem_addr_q    <= mem_addr_d;
            data_q        <= data_d;
            start_cnt_q   <= start_cnt_d;
            word_ready_q  <= word_ready_d;
            mem_we_q      <= mem_we_d;
            start_press_q <= start_press_d;
            done_q        <= done_d;
        end
    end

    assign WORD_READY  = word_ready_q;
    assign MEM_WE      = mem_we_q;
    assign MEM_ADDR    = mem_addr_q;
    assign MEM_DATA    = data_q;
    assign START_PRESS = start_press_q;
    assign BUSY        = (state_q != ST_IDLE);
    assign DONE        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_core_image_loader.sv
`default_nettype none
// Testbench for core_image_loader: random loads scored against an address/data
// queue model, plus START/DONE timing and abort/reset scenarios.
module tb_core_image_loader;

    localparam int SC = 1000;

    logic        CL, RESET, LOAD_REQ, ABORT, WORD_VALID, MEM_BUSY;
    logic [14:0] LOAD_ORG, LOAD_COUNT;
    logic [35:0] WORD_DATA;
    logic        WORD_READY, MEM_WE, START_PRESS, BUSY, DONE;
    logic [14:0] MEM_ADDR;
    logic [35:0] MEM_DATA;
    logic        m_word_ready, m_mem_we, m_start_press, m_busy, m_done;
    logic [14:0] m_mem_addr;
    logic [35:0] m_mem_data;

    core_image_loader #(.START_CYCLES(SC), .AUTO_START(1'b1)) u_dut (
        .CL(CL), .RESET(RESET), .LOAD_REQ(LOAD_REQ), .LOAD_ORG(LOAD_ORG),
        .LOAD_COUNT(LOAD_COUNT), .ABORT(ABORT), .WORD_VALID(WORD_VALID),
        .WORD_DATA(WORD_DATA), .WORD_READY(WORD_READY), .MEM_BUSY(MEM_BUSY),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .START_PRESS(START_PRESS), .BUSY(BUSY), .DONE(DONE)
    );

    core_image_loader #(.START_CYCLES(SC), .AUTO_START(1'b0)) u_dut_manual (
        .CL(CL), .RESET(RESET), .LOAD_REQ(LOAD_REQ), .LOAD_ORG(LOAD_ORG),
        .LOAD_COUNT(LOAD_COUNT), .ABORT(ABORT), .WORD_VALID(WORD_VALID),
        .WORD_DATA(WORD_DATA), .WORD_READY(m_word_ready), .MEM_BUSY(MEM_BUSY),
        .MEM_WE(m_mem_we), .MEM_ADDR(m_mem_addr), .MEM_DATA(m_mem_data),
        .START_PRESS(m_start_press), .BUSY(m_busy), .DONE(m_done)
    );

    initial begin
        CL = 1'b0;
        forever #5 CL = ~CL;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({WORD_READY, MEM_WE, MEM_ADDR, MEM_DATA, START_PRESS, BUSY, DONE});
    endfunction

    // Model: each accepted word must be written once at ORG + index (mod 2^15).
    logic [50:0] exp_q[$];
    logic [50:0] exp_e;
    logic [14:0] exp_addr;
    int          exp_left, exp_count;
    int          writes, total_we, hs_cnt, hs_base, n_words;
    int          sp_run, last_sp, busy_mode;
    bit          sp_prev, sp_cut, done_due, we_seen, src_en, gaps;
    logic [14:0] log_addr[64];
    logic [35:0] log_data[64];
    logic [35:0] img[64];
    logic [35:0] img_sort[64];

    always @(negedge CL) begin
        we_seen = MEM_WE;
        if (RESET) begin
            sp_prev = 1'b0;
            sp_run  = 0;
        end else begin
            if (MEM_WE) begin
                total_we++;
                chk("we_while_busy", 64'(MEM_BUSY), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("spurious_we", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("we_addr", 64'(MEM_ADDR), 64'(exp_e[50:36]));
                    chk("we_data", 64'(MEM_DATA), 64'(exp_e[35:0]));
                    if (writes < 64) begin
                        log_addr[writes] = MEM_ADDR;
                        log_data[writes] = MEM_DATA;
                    end
                    writes++;
                end
            end
            if (WORD_VALID && WORD_READY) begin
                chk("one_in_flight", 64'(exp_q.size()), 64'd0);
                chk("accept_within_count", 64'(exp_left > 0), 64'd1);
                if (exp_left > 0) begin
                    exp_q.push_back({exp_addr, WORD_DATA});
                    exp_addr = exp_addr + 15'd1;
                    exp_left--;
                end
                hs_cnt++;
            end
            if (START_PRESS) begin
                sp_run++;
            end else if (sp_prev) begin
                if (!sp_cut) chk("start_len", 64'(sp_run), 64'(SC));
                last_sp = sp_run;
                sp_run  = 0;
            end
            done_due = sp_prev && !START_PRESS && !sp_cut;
            if (DONE || done_due) chk("done_timing", 64'(DONE), 64'(done_due));
            if (DONE) begin
                chk("writes_at_done", 64'(writes), 64'(exp_count));
                chk("pending_at_done", 64'(exp_q.size()), 64'd0);
            end
            if (m_start_press) chk("manual_no_start", 64'(m_start_press), 64'd0);
            sp_prev = START_PRESS;
        end
    end

    // Word source: presents img[] in order, optionally with random gaps.
    initial begin
        int idx;
        WORD_VALID = 1'b0;
        WORD_DATA  = 36'd0;
        forever begin
            @(posedge CL);
            #1;
            idx        = hs_cnt - hs_base;
            WORD_VALID = src_en && (idx < n_words) && (!gaps || ($urandom_range(0, 2) != 0));
            WORD_DATA  = (idx < 64) ? img[idx] : 36'd0;
        end
    end

    // Storage: busy for a number of cycles after every write it receives.
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        MEM_BUSY = 1'b0;
        forever begin
            @(posedge CL);
            #1;
            if (we_seen) busy_cnt = (busy_mode == 1) ? 5 : (busy_mode == 2) ? int'($urandom_range(0, 5)) : 0;
            MEM_BUSY = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
        end
    end

    task automatic start_load(input logic [14:0] org, input int cnt, input bit g, input int bm);
        gaps      = g;
        busy_mode = bm;
        exp_addr  = org;
        exp_left  = cnt;
        exp_count = cnt;
        writes    = 0;
        exp_q.delete();
        hs_base   = hs_cnt;
        n_words   = cnt;
        src_en    = 1'b1;
        LOAD_ORG   = org;
        LOAD_COUNT = 15'(cnt);
        LOAD_REQ   = 1'b1;
        repeat (3) @(posedge CL);
        #1 LOAD_REQ = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!DONE && k < limit) begin
            @(negedge CL);
            k++;
        end
        chk("done_seen", 64'(DONE), 64'd1);
        @(posedge CL);
        #1;
    endtask

    task automatic run_load(input logic [14:0] org, input int cnt, input bit g, input int bm);
        start_load(org, cnt, g, bm);
        wait_done(cnt * 20 + SC + 50);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) img[i] = 36'({$urandom(), $urandom()});
    endtask

    initial begin
        int k;
        int we_snap;
        RESET = 1'b0; LOAD_REQ = 1'b0; ABORT = 1'b0; LOAD_ORG = '0; LOAD_COUNT = '0;
        src_en = 1'b0; gaps = 1'b0; busy_mode = 0; sp_cut = 1'b0; sp_prev = 1'b0;
        writes = 0; total_we = 0; hs_cnt = 0; hs_base = 0; n_words = 0; sp_run = 0; last_sp = 0;
        exp_left = 0; exp_count = 0; exp_addr = '0; we_seen = 1'b0;

        #2 RESET = 1'b1;
        #1 chk("reset_outputs", outs_vec(), 64'd0);
        repeat (3) @(posedge CL);
        #1 RESET = 1'b0;
        repeat (2) @(posedge CL);
        #1;

        // Sort image, no gaps.
        fill_random(25);
        img[0]  = 36'o053400200015;
        img[24] = 36'o000000000301;
        for (int i = 0; i < 25; i++) img_sort[i] = img[i];
        run_load(15'o00000, 25, 1'b0, 0);
        chk("sort_first_addr", 64'(log_addr[0]), 64'd0);
        chk("sort_first_data", 64'(log_data[0]), 64'o053400200015);
        chk("sort_last_addr", 64'(log_addr[24]), 64'o30);
        chk("sort_last_data", 64'(log_data[24]), 64'o301);
        chk("sort_start_len", 64'(last_sp), 64'(SC));

        // Address wrap.
        fill_random(3);
        run_load(15'o77776, 3, 1'b0, 0);
        chk("wrap_addr0", 64'(log_addr[0]), 64'o77776);
        chk("wrap_addr1", 64'(log_addr[1]), 64'o77777);
        chk("wrap_addr2", 64'(log_addr[2]), 64'o00000);

        // Stalls: gappy source, storage busy five cycles per write.
        for (int i = 0; i < 25; i++) img[i] = img_sort[i];
        run_load(15'o00000, 25, 1'b1, 1);
        chk("stall_writes", 64'(writes), 64'd25);
        chk("stall_last_data", 64'(log_data[24]), 64'o301);

        // COUNT = 0 on both loaders.
        exp_count = 0; writes = 0; exp_left = 0; exp_q.delete(); n_words = 0; hs_base = hs_cnt;
        LOAD_ORG = 15'o01234; LOAD_COUNT = 15'd0; LOAD_REQ = 1'b1;
        @(posedge CL); #1 chk("zero_manual_done_early", 64'(m_done), 64'd0);
        @(posedge CL); #1 chk("zero_manual_done", 64'(m_done), 64'd1);
        chk("zero_busy", 64'(BUSY), 64'd1);
        @(posedge CL); #1 chk("zero_manual_done_once", 64'(m_done), 64'd0);
        LOAD_REQ = 1'b0;
        wait_done(SC + 20);
        chk("zero_start_len", 64'(last_sp), 64'(SC));

        // Reset after the 10th write.
        fill_random(20);
        start_load(15'($urandom()), 20, 1'b0, 1);
        k = 0;
        while (writes < 10 && k < 1000) begin
            @(negedge CL);
            #1;
            k++;
        end
        chk("reset_mid_reached", 64'(writes), 64'd10);
        #1 RESET = 1'b1;
        #1 chk("reset_mid_outputs", outs_vec(), 64'd0);
        we_snap = total_we;
        src_en = 1'b0; exp_q.delete(); exp_left = 0; exp_count = 0;
        repeat (3) @(posedge CL);
        #1 RESET = 1'b0;
        repeat (40) @(posedge CL);
        #1 chk("no_write_after_reset", 64'(total_we - we_snap), 64'd0);
        chk("reset_mid_busy", 64'(BUSY), 64'd0);
        fill_random(6);
        run_load(15'($urandom()), 6, 1'b0, 0);

        // ABORT during START.
        fill_random(4);
        start_load(15'($urandom()), 4, 1'b0, 0);
        k = 0;
        while (!START_PRESS && k < 200) begin
            @(posedge CL);
            #1;
            k++;
        end
        chk("abort_start_seen", 64'(START_PRESS), 64'd1);
        repeat (100) @(posedge CL);
        #1 sp_cut = 1'b1; ABORT = 1'b1;
        @(posedge CL); #1 ABORT = 1'b0;
        chk("abort_start_press", 64'(START_PRESS), 64'd0);
        chk("abort_busy", 64'(BUSY), 64'd0);
        chk("abort_done", 64'(DONE), 64'd0);
        repeat (20) @(posedge CL);
        #1 sp_cut = 1'b0;
        fill_random(5);
        run_load(15'($urandom()), 5, 1'b1, 2);

        // ABORT together with a LOAD_REQ edge.
        exp_count = 0; writes = 0; exp_left = 0; exp_q.delete(); n_words = 0; hs_base = hs_cnt;
        LOAD_ORG = 15'o00100; LOAD_COUNT = 15'd5; LOAD_REQ = 1'b1; ABORT = 1'b1;
        repeat (2) @(posedge CL);
        #1 ABORT = 1'b0;
        chk("abort_edge_busy0", 64'(BUSY), 64'd0);
        @(posedge CL); #1 chk("abort_edge_busy1", 64'(BUSY), 64'd0);
        LOAD_REQ = 1'b0;
        repeat (2) @(posedge CL);
        #1;

        // LOAD_REQ pulsed mid-load.
        fill_random(15);
        start_load(15'($urandom()), 15, 1'b1, 2);
        k = 0;
        while (writes < 5 && k < 1000) begin
            @(posedge CL);
            #1;
            k++;
        end
        LOAD_ORG = 15'($urandom()); LOAD_COUNT = 15'd7; LOAD_REQ = 1'b1;
        @(posedge CL); #1 LOAD_REQ = 1'b0;
        @(posedge CL); #1 LOAD_REQ = 1'b1;
        repeat (2) @(posedge CL);
        #1 LOAD_REQ = 1'b0;
        wait_done(15 * 20 + SC + 50);
        chk("midload_writes", 64'(writes), 64'd15);
        repeat (5) @(posedge CL);
        #1 chk("midload_idle", 64'(BUSY), 64'd0);

        // Randomized loads.
        for (int r = 0; r < 5; r++) begin
            int cnt;
            cnt = $urandom_range(1, 40);
            fill_random(cnt);
            run_load(15'($urandom()), cnt, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
